// File: rtl/dds_pll_pkg.sv
// Shared types and defaults for the DDS PLL blocks: phase accumulator, control logic, frequency meter.
package dds_pll_pkg;

    localparam int unsigned DEF_ACC_W     = 16;
    localparam int unsigned DEF_GATE_LOG2 = 10;
    localparam int unsigned DEF_TOL       = 4;

    // Frequency tuning word as consumed by the phase accumulator.
    typedef logic [DEF_ACC_W-1:0] ftw_t;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } meter_state_e;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer followed by a delay flop; emits a registered one-cycle pulse per rising edge.
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_dly <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_1   <= din;
            sync_2   <= sync_1;
            sync_dly <= sync_2;
            rise     <= sync_2 & ~sync_dly;
        end
    end

endmodule

// File: rtl/dds_freq_meter.sv
// Gated edge counter: counts Sig_In rising edges over 2^GATE_LOG2 clocks and reports the
// count scaled to an FTW, with Valid/Ack handshake, sticky Overrun and a Stable indicator.
module dds_freq_meter #(
    parameter int unsigned ACC_W     = dds_pll_pkg::DEF_ACC_W,
    parameter int unsigned GATE_LOG2 = dds_pll_pkg::DEF_GATE_LOG2,
    parameter int unsigned TOL       = dds_pll_pkg::DEF_TOL
) (
    input  logic             DDS_Clk,
    input  logic             Reset,
    input  logic             Sig_In,
    input  logic             Run,
    input  logic             Ack,
    output logic [ACC_W-1:0] FTW_Est,
    output logic             Valid,
    output logic             Overrun,
    output logic             Stable
);
    import dds_pll_pkg::*;

    localparam int unsigned          SHIFT    = ACC_W - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] GATE_MAX = '1;

    meter_state_e         state;
    logic [GATE_LOG2-1:0] gate_cnt;
    logic [GATE_LOG2-1:0] edge_cnt;
    logic [GATE_LOG2-1:0] final_cnt;
    logic                 close_q;
    logic                 have_prev;
    logic                 sig_rise;
    logic [ACC_W-1:0]     new_ftw_c;
    logic [ACC_W-1:0]     diff_c;

    sig_sync_edge u_sync (
        .clk  (DDS_Clk),
        .rst  (Reset),
        .din  (Sig_In),
        .rise (sig_rise)
    );

    // Scaled result of the window that just closed and its distance from the current estimate.
    always_comb begin
        new_ftw_c = ACC_W'(final_cnt) << SHIFT;
        diff_c    = (new_ftw_c >= FTW_Est) ? (new_ftw_c - FTW_Est) : (FTW_Est - new_ftw_c);
    end

    always_ff @(posedge DDS_Clk) begin
        if (Reset) begin
            state     <= IDLE;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            final_cnt <= '0;
            close_q   <= 1'b0;
            have_prev <= 1'b0;
            FTW_Est   <= '0;
            Valid     <= 1'b0;
            Overrun   <= 1'b0;
            Stable    <= 1'b0;
        end else begin
            close_q <= 1'b0;

            if (Ack) begin
                Valid   <= 1'b0;
                Overrun <= 1'b0;
            end

            // Publish the window captured on the previous edge; a new result beats a coincident Ack.
            if (close_q && Run) begin
                FTW_Est   <= new_ftw_c;
                Valid     <= 1'b1;
                Stable    <= have_prev && (diff_c <= ACC_W'(TOL));
                have_prev <= 1'b1;
                if (Valid && !Ack) begin
                    Overrun <= 1'b1;
                end
            end

            if (!Run) begin
                Stable    <= 1'b0;
                have_prev <= 1'b0;
            end

            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (Run) begin
                        state <= GATE;
                    end
                end
                GATE: begin
                    if (!Run) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + GATE_LOG2'(1);
                        // Back-to-back windows: the last-cycle edge belongs to the closing window.
                        if (gate_cnt == GATE_MAX) begin
                            final_cnt <= edge_cnt + GATE_LOG2'(sig_rise);
                            edge_cnt  <= '0;
                            close_q   <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + GATE_LOG2'(sig_rise);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/dds_freq_meter.md
# dds_freq_meter

Measures the frequency of an external signal by counting its rising edges over a fixed gate window of DDS clock cycles. Reports the result directly as a 16-bit frequency tuning word (FTW) in the same scale the phase accumulator consumes. It runs in the reverse direction of the phase accumulator: a waveform comes in and an FTW comes out. It seeds the control logic with a coarse initial FTW before the PFD loop takes over, and serves as an independent lock check on DDS_Out.

## Interface
- ACC_W, 16: accumulator/FTW width; must be ≥ GATE_LOG2.
- GATE_LOG2, 10: gate window = 2^GATE_LOG2 DDS_Clk cycles.
- TOL, 4: maximum |FTW difference| between consecutive windows for Stable.
- DDS_Clk  in  1  sole clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Sig_In  in  1  asynchronous signal to be measured.
- Run  in  1  level; 1 = measure continuously, 0 = idle.
- Ack  in  1  consumer acknowledge of current result.
- FTW_Est  out  ACC_W  latest estimate = edge_count << (ACC_W − GATE_LOG2).
- Valid  out  1  new result available, held until Ack.
- Overrun  out  1  sticky: a result was overwritten while Valid = 1.
- Stable  out  1  last two consecutive estimates within TOL.

## Operation
- Sig_In passes through a 2-flop synchronizer, then a delay flop. A rising edge is detected when the synced value is 1 and the delayed value is 0.
- States:
  - IDLE → GATE when Run = 1.
  - GATE → GATE on window wrap while Run = 1.
  - any state → IDLE when Run = 0.
- GATE behaviour:
  - gate_cnt (GATE_LOG2 bits) runs 0..2^GATE_LOG2−1.
  - edge_cnt (GATE_LOG2 bits) increments on each detected edge.
  - At gate_cnt = max, both counters restart at 0 for the next window; there are no dead cycles.
- Edge detected in the last window cycle is counted in the closing window.
- edge_cnt cannot overflow: at most 2^(GATE_LOG2−1) rising edges fit in one window.
- Window close:
  - FTW_Est ← final count << (ACC_W − GATE_LOG2).
  - prev ← old FTW_Est.
  - Valid ← 1.
  - If Valid was already 1 and Ack = 0 in that cycle, Overrun ← 1.
- Ack = 1 clears Valid and Overrun next cycle. If Ack coincides with window close, the new result wins: Valid stays 1 and Overrun is not set.
- Stable ← (|new − FTW_Est| ≤ TOL) AND at least one earlier window completed since entering GATE; evaluated at each window close. Stable clears on Run = 0.
- Run = 0 mid-window: the partial window is discarded. FTW_Est and Valid hold; counters clear.
- Reset: all state, counters and synchronizer flops → 0; state → IDLE. Takes priority over every other input.

## Timing
- Reset values: FTW_Est = 0, Valid = 0, Overrun = 0, Stable = 0.
- Edge latency: a Sig_In rising edge is counted 3 DDS_Clk cycles after the first clock edge that samples Sig_In = 1.
- Run sampled high at edge k → first GATE cycle (gate_cnt = 0) at edge k+1.
- Window close at the edge where gate_cnt = max. FTW_Est and Valid update at the following edge, and every 2^GATE_LOG2 cycles thereafter.
- Valid → 0 one cycle after Ack is sampled high.
- Sig_In frequency must be < DDS_Clk/2; higher input frequencies alias and are outside specification.

## Structure
- Package dds_pll_pkg holds:
  - state encoding (IDLE, GATE);
  - ACC_W default;
  - FTW width type shared with the phase accumulator and control logic.
- Sub-module sig_sync_edge: 2-flop synchronizer plus rising-edge pulse, with sync reset. It is reusable for REF_Clk sampling in the PFD.
- Top: state register, gate/edge counters, result/prev registers, Valid/Overrun/Stable logic.

## Test plan
- Period 8 clocks (4 high / 4 low), Run = 1 → each window counts 128 edges; FTW_Est = 8192; Valid rises 1025 cycles after Run; Stable = 1 after the second window.
- Sig_In toggling every clock (period 2) → FTW_Est = 32768. Sig_In held constant → FTW_Est = 0 with Valid still asserted.
- Never Ack across two windows → Overrun = 1 at the second close. Ack in the same cycle as a close → Valid stays 1 and Overrun stays 0. Ack alone → Valid and Overrun return to 0 next cycle.
- Frequency jitters between period 8 and period 9 over consecutive windows:
  - counts 128 vs 114 → Stable = 0;
  - counts 128 vs 128 → Stable = 1;
  - Run dropped → Stable = 0.
- Reset (or Run = 0) at gate_cnt = 500 → counters clear with no Valid pulse. After Run resumes, the first result arrives a full 1025 cycles later with the correct value.
